// File: rtl/speed_loop_pkg.sv
// speed_loop_pkg: shared widths, PI state encoding and the clamp helper for the speed loop.
package speed_loop_pkg;
    localparam int PHI_W  = 12;
    localparam int IQ_W   = 16;
    localparam int PROD_W = 41;
    localparam int ACC_W  = 48;

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL, S_SUM, S_OUT} state_t;

    function automatic logic signed [ACC_W-1:0] sat_s(
        input logic signed [ACC_W-1:0] value,
        input logic signed [ACC_W-1:0] limit
    );
        return value > limit ? limit : (value < -limit ? -limit : value);
    endfunction
endpackage

// File: rtl/speed_pi_loop_meas.sv
// speed_meas: decimates the control tick and differences the wrapped mechanical angle once per speed period.
module speed_meas
    import speed_loop_pkg::*;
#(
    parameter logic [15:0] DECIM = 16'd18
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [PHI_W-1:0]       phi,
    input  logic                   busy,
    output logic                   stb,
    output logic signed [IQ_W-1:0] delta
);
    localparam logic [15:0] LAST = DECIM - 16'd1;

    logic [15:0]      cnt;
    logic [PHI_W-1:0] phi_prev;
    logic [PHI_W-1:0] diff;
    logic             valid;
    logic             tick;

    assign tick  = en && cnt == LAST;
    // modulo-4096 difference read as two's complement gives the shortest signed path
    assign diff  = phi - phi_prev;
    assign delta = IQ_W'($signed(diff));
    assign stb   = tick && !busy && valid;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            cnt      <= '0;
            phi_prev <= '0;
            valid    <= 1'b0;
        end else begin
            if (en) cnt <= tick ? '0 : cnt + 16'd1;
            if (tick && !busy) begin
                phi_prev <= phi;
                valid    <= 1'b1;
            end
        end
endmodule

// File: rtl/speed_pi_loop.sv
// speed_pi_loop: decimated speed measurement feeding a saturating PI controller that sets the foc iq target.
module speed_pi_loop
    import speed_loop_pkg::*;
#(
    parameter logic [15:0] DECIM  = 16'd18,
    parameter logic [23:0] KP     = 24'd65536,
    parameter logic [23:0] KI     = 24'd256,
    parameter logic [15:0] IQ_MAX = 16'd400
) (
    input  logic                   rstn,
    input  logic                   clk,
    input  logic                   i_en,
    input  logic [PHI_W-1:0]       i_phi,
    input  logic                   i_enable,
    input  logic signed [IQ_W-1:0] i_speed_aim,
    output logic                   o_en,
    output logic signed [IQ_W-1:0] o_speed,
    output logic signed [IQ_W-1:0] o_iq_aim
);
    localparam logic signed [ACC_W-1:0]  ERR_LIM = 48'sd32767;
    localparam logic signed [ACC_W-1:0]  OUT_LIM = {32'd0, IQ_MAX};
    localparam logic signed [ACC_W-1:0]  INT_LIM = OUT_LIM <<< 16;
    localparam logic signed [PROD_W-1:0] KP_S    = {17'd0, KP};
    localparam logic signed [PROD_W-1:0] KI_S    = {17'd0, KI};

    state_t                    state;
    logic                      stb;
    logic signed [IQ_W-1:0]    delta;
    logic signed [IQ_W-1:0]    err;
    logic signed [IQ_W-1:0]    speed;
    logic signed [PROD_W-1:0]  p;
    logic signed [PROD_W-1:0]  i_inc;
    logic signed [ACC_W-1:0]   integ;
    logic signed [ACC_W-1:0]   integ_nxt;
    logic signed [ACC_W-1:0]   sum;

    speed_meas #(.DECIM(DECIM)) u_meas (
        .clk   (clk),
        .rstn  (rstn),
        .en    (i_en),
        .phi   (i_phi),
        .busy  (state != S_IDLE),
        .stb   (stb),
        .delta (delta)
    );

    assign integ_nxt = sat_s(integ + ACC_W'(i_inc), INT_LIM);
    assign sum       = (ACC_W'(p) + integ) >>> 16;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state    <= S_IDLE;
            o_en     <= 1'b0;
            o_speed  <= '0;
            o_iq_aim <= '0;
            err      <= '0;
            speed    <= '0;
            p        <= '0;
            i_inc    <= '0;
            integ    <= '0;
        end else begin
            o_en <= 1'b0;
            case (state)
                S_IDLE: if (stb) begin
                    err   <= IQ_W'(sat_s(ACC_W'(i_speed_aim) - ACC_W'(delta), ERR_LIM));
                    speed <= delta;
                    state <= S_ERR;
                end
                S_ERR: begin
                    p     <= KP_S * PROD_W'(err);
                    i_inc <= KI_S * PROD_W'(err);
                    state <= S_MUL;
                end
                S_MUL: begin
                    integ <= integ_nxt;
                    state <= S_SUM;
                end
                S_SUM: begin
                    o_iq_aim <= IQ_W'(sat_s(sum, OUT_LIM));
                    o_speed  <= speed;
                    o_en     <= 1'b1;
                    state    <= S_OUT;
                end
                default: state <= S_IDLE;
            endcase
            // a disabled loop overrides whatever the pipeline produced this cycle
            if (!i_enable) begin
                integ    <= '0;
                o_iq_aim <= '0;
            end
        end
endmodule

// File: tb/tb_speed_pi_loop.sv
// tb_speed_pi_loop: randomized scoreboard bench comparing the speed loop against an arithmetic reference model.
module tb_speed_pi_loop;
    localparam int DECIM  = 4;
    localparam int KP     = 65536;
    localparam int KI     = 8192;
    localparam int IQ_MAX = 400;

    typedef struct {
        longint speed;
        longint iq;
        longint cyc;
    } exp_t;

    logic               rstn;
    logic               clk = 1'b0;
    logic               i_en;
    logic [11:0]        i_phi;
    logic               i_enable;
    logic signed [15:0] i_speed_aim;
    logic               o_en;
    logic signed [15:0] o_speed;
    logic signed [15:0] o_iq_aim;

    exp_t   q[$];
    int     compared = 0;
    int     mismatched = 0;
    longint cyc = 0;
    int     ticks;
    bit     primed;
    int     prev;
    longint integ;
    int     phi;

    speed_pi_loop #(
        .DECIM  (16'(DECIM)),
        .KP     (24'(KP)),
        .KI     (24'(KI)),
        .IQ_MAX (16'(IQ_MAX))
    ) dut (
        .rstn        (rstn),
        .clk         (clk),
        .i_en        (i_en),
        .i_phi       (i_phi),
        .i_enable    (i_enable),
        .i_speed_aim (i_speed_aim),
        .o_en        (o_en),
        .o_speed     (o_speed),
        .o_iq_aim    (o_iq_aim)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lim);
        return v > lim ? lim : (v < -lim ? -lim : v);
    endfunction

    // reference: wrapped angle difference, then PI with clamped integrator, floor division by 2^16
    function automatic void model_sample(input int ph, input int aim, input longint c);
        int     d;
        longint err;
        exp_t   e;
        d = ((ph - prev) % 4096 + 4096) % 4096;
        if (d >= 2048) d -= 4096;
        prev = ph;
        err = clamp(longint'(aim) - d, 32767);
        if (i_enable) begin
            integ = clamp(integ + longint'(KI) * err, longint'(IQ_MAX) * 65536);
            e.iq  = clamp((longint'(KP) * err + integ) >>> 16, IQ_MAX);
        end else begin
            integ = 0;
            e.iq  = 0;
        end
        e.speed = d;
        e.cyc   = c;
        q.push_back(e);
    endfunction

    always @(negedge clk)
        if (rstn && o_en) begin
            exp_t e;
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL o_en_spurious: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                check("o_speed", o_speed, e.speed);
                check("o_iq_aim", o_iq_aim, e.iq);
                check("o_en_latency", cyc, e.cyc);
            end
        end

    task automatic tick(input int ph, input int aim);
        @(negedge clk);
        i_phi       = 12'(ph);
        i_speed_aim = 16'(aim);
        i_en        = 1'b1;
        ticks++;
        if (ticks % DECIM == 0) begin
            if (!primed) begin
                primed = 1'b1;
                prev   = ph;
            end else model_sample(ph, aim, cyc + 4);
        end
        @(negedge clk);
        i_en  = 1'b0;
        i_phi = 12'($urandom);
        repeat ($urandom_range(4, 8)) @(negedge clk);
    endtask

    task automatic period(input int ph, input int aim);
        for (int k = 0; k < DECIM - 1; k++) tick(int'($urandom_range(0, 4095)), int'($urandom_range(0, 200)) - 100);
        tick(ph, aim);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; i_en = 1'b0; i_enable = 1'b1; i_phi = '0; i_speed_aim = '0;
        ticks = 0; primed = 1'b0; integ = 0; prev = 0;
        repeat (3) @(negedge clk);
        check("reset_o_en", o_en, 0);
        check("reset_o_speed", o_speed, 0);
        check("reset_o_iq_aim", o_iq_aim, 0);
        rstn = 1'b1;
        phi = 100;
        period(phi, 30);
        repeat (4) begin phi += 10; period(phi, 30); end
        period(4090, 0); period(5, 0); period(4090, 0);
        repeat (5) period(4090, 2000);
        repeat (5) period(4090, -2000);
        period(5, 0); period(4090, 32767); period(5, -32768);
        repeat (12) period(5, 10);
        repeat (3) period(5, -10);
        repeat (3) period(5, 300);
        @(negedge clk);
        i_enable = 1'b0;
        integ = 0;
        @(negedge clk);
        check("iq_after_disable", o_iq_aim, 0);
        repeat (2) period(5, 50);
        i_enable = 1'b1;
        repeat (3) period(5, 5);
        repeat (2) period(5, 2000);
        // reset lands while the pipeline is two stages into a sample
        for (int k = 0; k < DECIM - 1; k++) tick(int'($urandom_range(0, 4095)), 0);
        @(negedge clk);
        i_phi = 12'd700; i_speed_aim = 16'sd2000; i_en = 1'b1;
        @(negedge clk);
        i_en = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midreset_o_en", o_en, 0);
        check("midreset_o_speed", o_speed, 0);
        check("midreset_o_iq_aim", o_iq_aim, 0);
        q.delete();
        ticks = 0; primed = 1'b0; integ = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        phi = 1000;
        period(phi, 100);
        phi += 20;
        period(phi, 100);
        repeat (40) begin
            int step;
            step = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 120)) - 60;
            phi = ((phi + step) % 4096 + 4096) % 4096;
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                i_enable = !i_enable;
                if (!i_enable) integ = 0;
            end
            period(phi, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 800)) - 400);
        end
        i_enable = 1'b1;
        repeat (10) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/speed_pi_loop.md
Name: speed_pi_loop

Overview:
Outer speed loop that sits directly upstream of foc_top and drives its iq_aim input; it replaces the fixed ±200 toggle.
- Uses the foc_top en_idq pulse (one per 2048 clk control period) as its sample tick.
- Decimates the tick, measures mechanical speed by differencing the AS5600 angle phi with wrap-around.
- Runs a saturating PI controller with anti-windup and outputs a new iq_aim once per speed period.

Parameters:
- DECIM, 16'd18: i_en ticks per speed period (18 kHz / 18 = 1 kHz speed loop); legal range 1..65535.
- Kp, 24'd65536: proportional gain, unsigned, Q8.16 (65536 = 1.0).
- Ki, 24'd256: integral gain per speed period, unsigned, Q8.16.
- IQ_MAX, 16'd400: output and integrator clamp magnitude; legal range 1..32767.

Ports:
- rstn, input, 1: asynchronous, active-low reset.
- clk, input, 1: clock.
- i_en, input, 1: sample tick, single-cycle pulse (connected to en_idq).
- i_phi, input, 12: mechanical angle 0..4095, unsigned.
- i_enable, input, 1: 1 = closed loop; 0 = output forced to 0 and integrator cleared.
- i_speed_aim, input, signed 16: target speed, in phi LSB per speed period.
- o_en, output, 1: single-cycle pulse when o_speed and o_iq_aim update.
- o_speed, output, signed 16: measured speed, phi LSB per speed period.
- o_iq_aim, output, signed 16: q-axis current target for foc_top.

Behaviour:
Reset:
- Reset is rstn, asynchronous, active-low; clock is clk.
- On reset, o_en=0, o_speed=0, o_iq_aim=0, tick counter=0, integrator=0, phi_prev=0, valid=0, state=S_IDLE.

Decimation:
- The tick counter increments on each i_en.
- When the counter is at DECIM-1 and i_en is high, the counter returns to 0 and i_phi is sampled (the sampling tick).

Speed measurement:
- delta = (i_phi − phi_prev) mod 4096, taken as a 12-bit two's-complement value and sign-extended to 16 bits. Range is −2048..+2047.
- Wrap examples: 4090→5 gives +11; 5→4090 gives −11.
- phi_prev is updated to i_phi on every sampling tick.
- On the first sampling tick after reset, only phi_prev is latched and valid is set. No o_en pulse is produced, and outputs hold 0.

State machine (one state per cycle after the sampling tick):
- S_IDLE → S_ERR: err = sat16(i_speed_aim − delta), computed 17-bit then saturated to ±32767.
- S_ERR → S_MUL:
  - p = Kp*err, 41-bit signed.
  - i_inc = Ki*err.
- S_MUL → S_SUM: integ = clamp(integ + i_inc, ±(IQ_MAX<<16)), 48-bit signed (anti-windup).
- S_SUM → S_OUT: sum = (p + integ) >>> 16, arithmetic shift; then clamp to ±IQ_MAX.
- S_OUT → S_IDLE: o_iq_aim and o_speed update; o_en pulses for one cycle.

Latency:
- o_en is high exactly 4 clk after the cycle in which the sampling i_en is high.
- o_iq_aim and o_speed are stable from that cycle until the next update.

Tick spacing and busy rule:
- i_en pulses are guaranteed ≥5 clk apart (2048 in the system).
- A sampling tick that arrives while the FSM is not in S_IDLE is dropped. phi_prev is not updated and the counter still wraps.

i_enable handling:
- When i_enable=0, integ is held at 0 and the o_iq_aim register is 0 on the next clk edge.
- Speed measurement and o_en pulses continue, and o_iq_aim stays 0.
- On re-enable, the PI restarts from integ=0 with no bump beyond the P term.

Rounding:
- The >>>16 rounds toward −∞; there is no rounding correction.

Decomposition:
- Package speed_loop_pkg holds:
  - PHI_W=12, IQ_W=16, PROD_W=41, ACC_W=48.
  - typedef enum state_t {S_IDLE, S_ERR, S_MUL, S_SUM, S_OUT}.
  - Function sat_s(value, limit), used for every clamp.
- Sub-module speed_meas contains the decimation counter, phi_prev, the wrap-aware differencer and the valid flag. It outputs a 1-cycle sample strobe plus a signed 16-bit delta.
- speed_pi_loop instantiates speed_meas and holds the PI FSM.

Test Plan:
- Proportional response: DECIM=4, Kp=65536, Ki=0, aim=30; phi advances +10 per speed period → after the first (priming) period, o_speed=10 and o_iq_aim=20 on each o_en; o_en occurs 4 clk after every 4th i_en.
- Wrap-around: phi sampled 4090 then 5 → o_speed=+11. Phi sampled 5 then 4090 → o_speed=−11, and with aim=0, Kp=65536, o_iq_aim=+11.
- Output saturation: Kp=65536, Ki=0, IQ_MAX=400, aim=2000, phi static → o_iq_aim=400. With aim=−2000 → o_iq_aim=−400.
- Integrator and anti-windup: Kp=0, Ki=65536, err constant +10 → o_iq_aim = 10, 20, 30, … up to 400 and holds. Then err=−10 → the next output is 390 immediately, with no windup delay.
- i_enable drop: during a loop where o_iq_aim=250, deassert i_enable → o_iq_aim=0 the next clk. Reassert with err=5, Kp=0, Ki=65536 → the first output is 5.
- Reset mid-operation: assert rstn=0 while in S_MUL → all outputs 0 immediately. After release, the first sampling tick only primes, with no o_en; the next tick produces a valid update.
